// File: rtl/pipe_delay_line.sv
// pipe_delay_line: parametrised register delay line with per-stage valid bits,
// stall, synchronous flush and a runtime-selectable output tap. Used to align
// operands and control across pipeline paths whose latency varies per cycle.
module pipe_delay_line #(
    parameter int               WIDTH = 4,
    parameter int               DEPTH = 3,
    parameter logic [WIDTH-1:0] INIT  = '0,
    parameter int               SELW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int               CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic [WIDTH-1:0] I,
    input  logic             I_VALID,
    input  logic             EN,
    input  logic             FLUSH,
    input  logic [SELW-1:0]  SEL,
    output logic [WIDTH-1:0] O,
    output logic             O_VALID,
    output logic [CNTW-1:0]  OCCUPANCY
);

    // Deepest stage index; any larger SEL is clamped here rather than wrapped.
    localparam logic [SELW-1:0] LAST_TAP = SELW'(DEPTH - 1);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [SELW-1:0]  w_tap;
    logic [CNTW-1:0]  w_occ;

    // Stage shift register: flush beats enable, enable beats hold.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            // NOTE: the data stages are reset as well as the valid bits because
            // O must read INIT while reset is held; a valid-only reset would
            // leave stale or X data visible on the tap.
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= INIT;
            end
            r_valid <= '0;
        end else if (FLUSH) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= INIT;
            end
            r_valid <= '0;
        end else if (EN) begin
            // NOTE: non-blocking assignments make every stage take its
            // neighbour's old value; blocking ones would ripple I down the
            // whole chain in a single edge.
            r_data[0]  <= I;
            r_valid[0] <= I_VALID;
            for (int k = 1; k < DEPTH; k++) begin
                r_data[k]  <= r_data[k-1];
                r_valid[k] <= r_valid[k-1];
            end
        end
    end

    // Tap select: clamp out-of-range SEL to the last stage.
    always_comb begin
        // NOTE: w_tap gets a value on every path before it is conditionally
        // overridden, so no latch is inferred.
        w_tap = SEL;
        if (SEL > LAST_TAP) begin
            w_tap = LAST_TAP;
        end
    end

    // Occupancy: popcount of the registered valid bits, independent of SEL.
    always_comb begin
        w_occ = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_occ = w_occ + CNTW'(r_valid[k]);
        end
    end

    assign O         = r_data[w_tap];
    assign O_VALID   = r_valid[w_tap];
    assign OCCUPANCY = w_occ;

endmodule

// File: tb/tb_pipe_delay_line.sv
// Self-checking bench for pipe_delay_line (WIDTH=4, DEPTH=3, INIT=4'hA):
// a directed vector table, hand-written multi-cycle sequences and a random
// phase against a queue-based reference model.
module tb_pipe_delay_line;

    localparam int               WIDTH = 4;
    localparam int               DEPTH = 3;
    localparam logic [WIDTH-1:0] INIT  = 4'hA;
    localparam int               SELW  = 2;
    localparam int               CNTW  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] i_d;
    logic             iv;
    logic             en;
    logic             flush;
    logic [SELW-1:0]  sel;
    logic [WIDTH-1:0] o;
    logic             ov;
    logic [CNTW-1:0]  occ;

    int n_vec = 0;
    int n_bad = 0;

    pipe_delay_line #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .INIT(INIT), .SELW(SELW), .CNTW(CNTW)
    ) dut (
        .CLK(clk), .ASYNCRESETN(rst_n), .I(i_d), .I_VALID(iv), .EN(en),
        .FLUSH(flush), .SEL(sel), .O(o), .O_VALID(ov), .OCCUPANCY(occ)
    );

    always #5 clk = ~clk;

    // Reference model: index 0 is the newest sample, index DEPTH-1 the oldest.
    logic [WIDTH-1:0] q_data [$];
    bit               q_v    [$];

    task automatic model_clear();
        q_data.delete();
        q_v.delete();
        repeat (DEPTH) begin
            q_data.push_back(INIT);
            q_v.push_back(1'b0);
        end
    endtask

    task automatic model_step();
        if (flush) begin
            model_clear();
        end else if (en) begin
            q_data.push_front(i_d);
            q_v.push_front(iv);
            void'(q_data.pop_back());
            void'(q_v.pop_back());
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        int t;
        int cnt;
        t   = (int'(sel) < DEPTH) ? int'(sel) : DEPTH - 1;
        cnt = 0;
        foreach (q_v[k]) cnt += int'(q_v[k]);
        check({tag, "_o"},   o,   q_data[t]);
        check({tag, "_v"},   ov,  q_v[t]);
        check({tag, "_occ"}, occ, cnt);
    endtask

    task automatic check_out(input string tag, input int eo, input int ev, input int eocc);
        check({tag, "_o"},   o,   eo);
        check({tag, "_v"},   ov,  ev);
        check({tag, "_occ"}, occ, eocc);
    endtask

    // One clock edge; the model follows the same inputs, outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic drive(input bit f, input bit e, input bit v, input int d, input int s);
        flush = f;
        en    = e;
        iv    = v;
        i_d   = WIDTH'(d);
        sel   = SELW'(s);
    endtask

    typedef struct {
        bit flush;
        bit en;
        bit iv;
        int din;
        int sel;
        int exp_o;
        bit exp_v;
        int exp_occ;
    } vec_t;

    function automatic vec_t mk(bit f, bit e, bit v, int d, int s, int eo, bit ev, int eocc);
        vec_t r;
        r.flush = f; r.en = e; r.iv = v; r.din = d; r.sel = s;
        r.exp_o = eo; r.exp_v = ev; r.exp_occ = eocc;
        return r;
    endfunction

    vec_t tbl [12];

    initial begin
        // Default chain, bubbles through the chain, refill, then flush priority.
        tbl[0]  = mk(0, 1, 1, 4'h1, 2, 4'hA, 0, 1);
        tbl[1]  = mk(0, 1, 1, 4'h2, 2, 4'hA, 0, 2);
        tbl[2]  = mk(0, 1, 1, 4'h3, 2, 4'h1, 1, 3);
        tbl[3]  = mk(0, 1, 1, 4'h4, 2, 4'h2, 1, 3);
        tbl[4]  = mk(0, 1, 1, 4'h5, 2, 4'h3, 1, 3);
        tbl[5]  = mk(0, 1, 0, 4'h0, 2, 4'h4, 1, 2);
        tbl[6]  = mk(0, 1, 0, 4'h0, 2, 4'h5, 1, 1);
        tbl[7]  = mk(0, 1, 1, 4'h6, 2, 4'h0, 0, 1);
        tbl[8]  = mk(0, 1, 1, 4'h7, 2, 4'h0, 0, 2);
        tbl[9]  = mk(0, 1, 1, 4'h8, 2, 4'h6, 1, 3);
        tbl[10] = mk(1, 1, 1, 4'hF, 2, 4'hA, 0, 0);
        tbl[11] = mk(0, 1, 0, 4'h3, 2, 4'hA, 0, 0);

        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0);

        // Reset value appears asynchronously, before any clock edge.
        #2 rst_n = 1'b0;
        model_clear();
        #1 check_out("reset", 4'hA, 0, 0);
        @(negedge clk) rst_n = 1'b1;

        // Directed table.
        for (int k = 0; k < 12; k++) begin
            drive(tbl[k].flush, tbl[k].en, tbl[k].iv, tbl[k].din, tbl[k].sel);
            tick();
            check_out($sformatf("tbl%0d", k), tbl[k].exp_o, tbl[k].exp_v, tbl[k].exp_occ);
        end

        // Tap switch without clocking: stages hold 7,6,5 (newest first).
        for (int d = 5; d <= 7; d++) begin
            drive(0, 1, 1, d, 2);
            tick();
        end
        en = 1'b0;
        begin
            int exp_tap [4] = '{7, 6, 5, 5};
            for (int s = 0; s < 4; s++) begin
                sel = SELW'(s);
                #1;
                check($sformatf("tap%0d_o", s), o, exp_tap[s]);
                check($sformatf("tap%0d_v", s), ov, 1);
            end
        end
        tick();
        check_model("tap_hold");

        // Stall: capture 9 with SEL=1, two stalled edges, then one enabled edge.
        drive(0, 1, 1, 9, 1);
        tick();
        check_model("stall_cap");
        en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            check_model($sformatf("stall%0d", k));
            check($sformatf("stall%0d_hold", k), o, 4'h7);
        end
        drive(0, 1, 0, 0, 1);
        tick();
        check_out("stall_out", 4'h9, 1, 2);

        // Bubbles: I_VALID 1,0,1 then idle with SEL=2, from a flushed state.
        drive(1, 0, 0, 0, 2);
        tick();
        check_out("flush_en0", 4'hA, 0, 0);
        begin
            bit bub_iv  [5] = '{1, 0, 1, 0, 0};
            bit bub_ev  [5] = '{0, 0, 1, 0, 1};
            int bub_occ [5] = '{1, 1, 2, 1, 1};
            for (int k = 0; k < 5; k++) begin
                drive(0, 1, bub_iv[k], k + 1, 2);
                tick();
                check($sformatf("bub%0d_v", k), ov, bub_ev[k]);
                check($sformatf("bub%0d_occ", k), occ, bub_occ[k]);
            end
        end

        // Mid-stream reset between edges, then recovery latency.
        drive(0, 1, 1, 6, 2);
        tick();
        #2 rst_n = 1'b0;
        model_clear();
        #1 check_out("midrst", 4'hA, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        drive(0, 1, 1, 4'hC, 2);
        tick();
        check_out("rel1", 4'hA, 0, 1);
        drive(0, 1, 0, 0, 2);
        tick();
        check_out("rel2", 4'hA, 0, 1);
        tick();
        check_out("rel3", 4'hC, 1, 1);

        // Random phase against the reference model.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                  1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
            tick();
            check_model($sformatf("rnd%0d", n));
            if ($urandom_range(0, 3) == 0) begin
                sel = SELW'($urandom_range(0, 3));
                #1 check_model($sformatf("rnd%0d_sel", n));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
